// File: rtl/sensor_scan_ctrl.sv
// rtl/sensor_scan_ctrl.sv - 16:1 sensor mux scanner, per-channel debounce and arm/exit-delay/alarm FSM
// Optional feature: define TAMPER_EN to add the tamper input and sticky tamper_flag output.
module sensor_scan_ctrl #(
  parameter int DWELL    = 4,
  parameter int DEBOUNCE = 3,
  parameter int EXIT_DLY = 255
) (
  input  logic        clk,
  input  logic        rst,
`ifdef TAMPER_EN
  input  logic        tamper,
  output logic        tamper_flag,
`endif
  input  logic        arm,
  input  logic        disarm,
  input  logic [15:0] zone_mask,
  input  logic        mux_out,
  output logic [3:0]  mux_sel,
  output logic [15:0] trip_vec,
  output logic        scan_done,
  output logic        armed,
  output logic        alarm,
  output logic [3:0]  alarm_zone
);

  typedef enum logic [1:0] {
    S_DISARMED,
    S_EXIT_DELAY,
    S_ARMED,
    S_ALARM
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  dwell;
  logic [1:0]  hits [16];
  logic [15:0] trip_q;
  logic [15:0] exit_cnt, exit_nx;
  logic [3:0]  zone_q, zone_nx;
  logic        sample;
  logic [1:0]  hit_cur, hit_nx;
  logic        trip_now;
  logic        qualify;

  assign sample   = (dwell == 4'(DWELL - 1));
  assign hit_cur  = hits[mux_sel];
  assign hit_nx   = !mux_out ? 2'd0 : ((hit_cur == 2'd3) ? 2'd3 : hit_cur + 2'd1);
  assign trip_now = (hit_nx >= 2'(DEBOUNCE));
  // Alarm decision uses the trip value being registered this cycle, not the stale one.
  assign qualify  = sample && trip_now && zone_mask[mux_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell   <= '0;
      mux_sel <= '0;
      trip_q  <= '0;
      for (int i = 0; i < 16; i++) hits[i] <= '0;
    end else if (sample) begin
      dwell         <= '0;
      mux_sel       <= mux_sel + 4'd1;
      hits[mux_sel] <= hit_nx;
      trip_q[mux_sel] <= trip_now;
    end else begin
      dwell <= dwell + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_DISARMED;
      exit_cnt <= '0;
      zone_q   <= '0;
    end else begin
      state    <= state_nx;
      exit_cnt <= exit_nx;
      zone_q   <= zone_nx;
    end
  end

  always_comb begin
    state_nx = state;
    exit_nx  = exit_cnt;
    zone_nx  = zone_q;
    case (state)
      S_DISARMED: begin
        if (arm && !disarm) begin
          state_nx = S_EXIT_DELAY;
          exit_nx  = '0;
        end
      end
      S_EXIT_DELAY: begin
        if (disarm)                             state_nx = S_DISARMED;
        else if (exit_cnt == 16'(EXIT_DLY - 1)) state_nx = S_ARMED;
        else                                    exit_nx  = exit_cnt + 16'd1;
      end
      S_ARMED: begin
        if (disarm) begin
          state_nx = S_DISARMED;
          zone_nx  = '0;
        end else if (qualify) begin
          state_nx = S_ALARM;
          zone_nx  = mux_sel;
        end
      end
      S_ALARM: begin
        if (disarm) begin
          state_nx = S_DISARMED;
          zone_nx  = '0;
        end
      end
      default: state_nx = S_DISARMED;
    endcase
`ifdef TAMPER_EN
    if (tamper) begin
      state_nx = S_ALARM;
      zone_nx  = 4'hF;
    end
`endif
  end

`ifdef TAMPER_EN
  always_ff @(posedge clk) begin
    if (rst) tamper_flag <= 1'b0;
    else     tamper_flag <= tamper_flag | tamper;
  end
`endif

  assign trip_vec   = trip_q;
  assign scan_done  = sample && (mux_sel == 4'hF);
  assign armed      = (state == S_ARMED) || (state == S_ALARM);
  assign alarm      = (state == S_ALARM);
  assign alarm_zone = zone_q;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// tb/tb_sensor_scan_ctrl.sv - scoreboard bench for sensor_scan_ctrl against a cycle-count reference model
module tb_sensor_scan_ctrl;
  localparam int DWELL    = 4;
  localparam int DEBOUNCE = 3;
  localparam int EXIT_DLY = 8;

  logic        clk = 1'b0;
  logic        rst, arm, disarm, mux_out;
  logic [15:0] zone_mask, sensor;
  logic [3:0]  mux_sel, alarm_zone;
  logic [15:0] trip_vec;
  logic        scan_done, armed, alarm;
  logic        tamper;
`ifdef TAMPER_EN
  logic        tamper_flag;
`endif

  always #5 clk = ~clk;
  assign mux_out = sensor[mux_sel];

  sensor_scan_ctrl #(.DWELL(DWELL), .DEBOUNCE(DEBOUNCE), .EXIT_DLY(EXIT_DLY)) dut (
    .clk(clk),
    .rst(rst),
`ifdef TAMPER_EN
    .tamper(tamper),
    .tamper_flag(tamper_flag),
`endif
    .arm(arm),
    .disarm(disarm),
    .zone_mask(zone_mask),
    .mux_out(mux_out),
    .mux_sel(mux_sel),
    .trip_vec(trip_vec),
    .scan_done(scan_done),
    .armed(armed),
    .alarm(alarm),
    .alarm_zone(alarm_zone)
  );

  typedef struct {
    int        sel;
    bit        done;
    bit [15:0] trip;
    bit        armed;
    bit        alarm;
    int        zone;
    bit        tflag;
  } exp_t;
  exp_t q[$];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: time since reset, integer hit counts, named mode
  int        t;
  int        hcnt [16];
  bit [15:0] m_trip;
  int        mode;  // 0 off, 1 exit delay, 2 armed, 3 alarm
  int        exit_left;
  int        m_zone;
  bit        m_tflag;
  int        m_ch;
  bit        m_samp, m_qual, m_tam;
  exp_t      e_new;

  always @(posedge clk) begin
    m_tam = 1'b0;
`ifdef TAMPER_EN
    m_tam = tamper;
`endif
    if (rst) begin
      t = 0; m_trip = '0; mode = 0; exit_left = 0; m_zone = 0; m_tflag = 0;
      for (int i = 0; i < 16; i++) hcnt[i] = 0;
    end else begin
      m_ch   = (t / DWELL) % 16;
      m_samp = (t % DWELL) == DWELL - 1;
      m_qual = 1'b0;
      if (m_samp) begin
        hcnt[m_ch]   = sensor[m_ch] ? ((hcnt[m_ch] + 1 > 3) ? 3 : hcnt[m_ch] + 1) : 0;
        m_trip[m_ch] = hcnt[m_ch] >= DEBOUNCE;
        m_qual       = m_trip[m_ch] && zone_mask[m_ch];
      end
      if (m_tam) begin
        mode = 3; m_zone = 15; m_tflag = 1;
      end else begin
        case (mode)
          0: if (arm && !disarm) begin mode = 1; exit_left = EXIT_DLY; end
          1: if (disarm) mode = 0;
             else begin
               exit_left--;
               if (exit_left == 0) mode = 2;
             end
          2: if (disarm) mode = 0;
             else if (m_qual) begin mode = 3; m_zone = m_ch; end
          default: if (disarm) begin mode = 0; m_zone = 0; end
        endcase
      end
      t++;
    end
    e_new.sel   = (t / DWELL) % 16;
    e_new.done  = ((t % DWELL) == DWELL - 1) && (e_new.sel == 15);
    e_new.trip  = m_trip;
    e_new.armed = (mode >= 2);
    e_new.alarm = (mode == 3);
    e_new.zone  = m_zone;
    e_new.tflag = m_tflag;
    q.push_back(e_new);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    else n_pass++;
  endtask

  exp_t e_mon;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      chk("mux_sel",    32'(mux_sel),    32'(e_mon.sel));
      chk("scan_done",  32'(scan_done),  32'(e_mon.done));
      chk("trip_vec",   32'(trip_vec),   32'(e_mon.trip));
      chk("armed",      32'(armed),      32'(e_mon.armed));
      chk("alarm",      32'(alarm),      32'(e_mon.alarm));
      chk("alarm_zone", 32'(alarm_zone), 32'(e_mon.zone));
`ifdef TAMPER_EN
      chk("tamper_flag", 32'(tamper_flag), 32'(e_mon.tflag));
`endif
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int idx;
  initial begin
    rst = 1; arm = 0; disarm = 0; zone_mask = '0; sensor = '0; tamper = 0;
    cyc(3);
    rst = 0;
    cyc(70);
    sensor[5] = 1'b1; cyc(3 * 64);
    sensor = '0; cyc(64);
    sensor[5] = 1'b1; cyc(64);
    sensor[5] = 1'b0; cyc(64);
    zone_mask = 16'h0200; sensor[9] = 1'b1;
    arm = 1; cyc(1); arm = 0;
    cyc(12);
    sensor[3] = 1'b1;
    cyc(200);
    arm = 1; disarm = 1; cyc(1);
    arm = 0; disarm = 0; sensor = '0;
    cyc(70);
    arm = 1; cyc(1); arm = 0;
    cyc(4);
    rst = 1; cyc(1); rst = 0;
    cyc(20);
`ifdef TAMPER_EN
    tamper = 1; cyc(2);
    disarm = 1; cyc(3);
    tamper = 0; cyc(2);
    disarm = 0; cyc(10);
`endif
    zone_mask = 16'hFFFF;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, 15);
        sensor[idx] = ~sensor[idx];
      end
      arm    = ($urandom_range(0, 39) == 0);
      disarm = ($urandom_range(0, 149) == 0);
      rst    = ($urandom_range(0, 799) == 0);
`ifdef TAMPER_EN
      tamper = ($urandom_range(0, 299) == 0);
`endif
      if ($urandom_range(0, 199) == 0) zone_mask = 16'($urandom);
      cyc(1);
    end
    arm = 0; disarm = 0; rst = 0; tamper = 0;
    cyc(4);
    @(negedge clk); #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
